ahbl_sram_slave: RTL and testbench
==================================

Name: ahbl_sram_slave

Overview:
- AHB-Lite responder (slave) backing a word-addressed on-chip SRAM.
- Answers the CPU instruction or data AHB-Lite master through the interconnect.
- Handles byte, halfword and word transfers, optional wait states, and a two-cycle ERROR response.
- Synthesizable; also serves as the memory endpoint in system simulation.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH*4.
- DEPTH, 1024, number of 32-bit words; power of two, minimum 16.
- WAIT_CYCLES, 1, wait states inserted per transfer when the wait-state feature is compiled in; range 0..7.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- hsel_i  in  1  slave select.
- haddr_i  in  32  address-phase address.
- htrans_i  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite_i  in  1  1=write, 0=read.
- hsize_i  in  3  0=byte, 1=half, 2=word; others are errors.
- hburst_i  in  3  accepted, ignored.
- hwdata_i  in  32  data-phase write data.
- hready_i  in  1  bus-level HREADY; address phase sampled only when 1.
- hreadyout_o  out  1  slave ready.
- hresp_o  out  1  0=OKAY, 1=ERROR.
- hrdata_o  out  32  read data, valid when hreadyout_o=1 in a read data phase.

Behaviour:
- Reset (async, rst_i=1):
  - hreadyout_o=1, hresp_o=0, hrdata_o=0.
  - FSM enters IDLE; pending-write valid flag cleared.
  - SRAM contents are not cleared.
- Transfer accepted at a rising edge when hsel_i & htrans_i[1] & hready_i. IDLE/BUSY get a zero-wait OKAY and cause no access.
- Address phase register holds word index (haddr_i-BASE_ADDR)>>2, byte lanes from haddr_i[1:0] and hsize_i (little-endian), and hwrite_i.
- Error check at acceptance, any one of:
  - address outside [BASE_ADDR, BASE_ADDR+DEPTH*4);
  - hsize_i>2;
  - misalignment: half with haddr_i[0]=1, or word with haddr_i[1:0]!=0.
- FSM states:
  - IDLE: no data phase pending.
  - WAIT: counting wait states.
  - DATA: final data-phase cycle, hreadyout_o=1.
  - ERR1: hresp_o=1, hreadyout_o=0.
  - ERR2: hresp_o=1, hreadyout_o=1.
- Transitions:
  - IDLE/DATA/ERR2 + accepted error transfer -> ERR1 -> ERR2.
  - IDLE/DATA/ERR2 + accepted valid transfer -> DATA if wait count is 0, else WAIT.
  - WAIT -> DATA when its counter reaches 0.
  - DATA/ERR2 with no new transfer -> IDLE.
  - Back-to-back pipelining: a new address phase accepted in DATA/ERR2 starts its own data phase the next cycle.
- Read:
  - SRAM read registered at the acceptance edge.
  - Zero-wait read data is on hrdata_o in the following cycle.
  - hrdata_o holds its last value outside read data phases.
- Write:
  - hwdata_i sampled at the edge ending the data phase (hreadyout_o=1).
  - Only the enabled byte lanes are committed.
- Read-after-write hazard: when a read is accepted on the same edge that commits a write to the same word, forward a byte-merge of the new write data over the old SRAM word. The read must never return stale bytes.
- Errored transfers never modify the SRAM and return hrdata_o unchanged.
- Reset mid-transfer: the FSM aborts to IDLE at once and an in-flight write is dropped.

Optional Feature:
- Macro AHBL_SRAM_WAIT_STATE_EN.
- Defined: every valid transfer holds hreadyout_o=0 for WAIT_CYCLES cycles before DATA. Read latency from acceptance is WAIT_CYCLES+1 cycles.
- Undefined: WAIT state and counter are not built; WAIT_CYCLES is ignored; all OKAY transfers are zero-wait.
- Error responses are two cycles in both builds.

Decomposition:
- Package ahbl_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HSIZE_BYTE/HALF/WORD;
  - HRESP_OKAY/ERROR;
  - FSM state enum;
  - a byte-lane function of (addr[1:0], size) -> 4-bit strobe.
- Sub-module ahbl_sram_mem: DEPTH x 32 single-port RAM with 4-bit byte-write enables and registered read.

Test Plan:
- Word write then read: write 32'hDEADBEEF to BASE+0x10, then read BASE+0x10 -> hrdata_o=32'hDEADBEEF, hresp_o=0, zero-wait in the non-wait build.
- Byte lanes: word 0x11223344 at BASE+0x20; byte write 0xAA to BASE+0x21; half write 0x5566 to BASE+0x22; word read BASE+0x20 -> 32'h5566AA44.
- Read-after-write back-to-back: NONSEQ write BASE+0x30 data 0x12345678 immediately followed by NONSEQ read BASE+0x30 -> hrdata_o=0x12345678 via forwarding.
- Errors:
  - read BASE+DEPTH*4 -> one cycle hresp_o=1/hreadyout_o=0, then hresp_o=1/hreadyout_o=1;
  - word write to BASE+0x02 -> same two-cycle ERROR, and a subsequent read of BASE+0x00 shows the word unchanged.
- Wait states (macro on, WAIT_CYCLES=3): read -> hreadyout_o low exactly 3 cycles, data valid on the 4th; BUSY/IDLE transfers stay zero-wait OKAY.
- Reset mid-transfer: assert rst_i during WAIT of a write to BASE+0x40 -> outputs immediately at reset values, and a later read of BASE+0x40 returns its pre-write value.

Source files
------------

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings, FSM state type and byte-lane decode for the SRAM responder.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } ahbl_state_e;

  // Little-endian lane strobe; illegal sizes enable nothing.
  function automatic logic [3:0] byte_lanes(input logic [1:0] addr, input logic [2:0] size);
    logic [3:0] lanes;
    case (size)
      HSIZE_BYTE: lanes = 4'b0001 << addr;
      HSIZE_HALF: lanes = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: lanes = 4'b1111;
      default:    lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/ahbl_sram_mem.sv
// DEPTH x 32 SRAM with byte-write enables and a registered read port.
module ahbl_sram_mem #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // A same-edge read of the word being written returns the old contents.
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) begin
        r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite responder in front of ahbl_sram_mem with two-cycle ERROR responses.
// Wait states are built only when AHBL_SRAM_WAIT_STATE_EN is defined.
module ahbl_sram_slave
  import ahbl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hsel_i,
  input  logic [31:0] haddr_i,
  input  logic [1:0]  htrans_i,
  input  logic        hwrite_i,
  input  logic [2:0]  hsize_i,
  input  logic [2:0]  hburst_i,
  input  logic [31:0] hwdata_i,
  input  logic        hready_i,
  output logic        hreadyout_o,
  output logic        hresp_o,
  output logic [31:0] hrdata_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  ahbl_state_e r_state, w_state_d;
  logic [AW-1:0] r_word;
  logic [3:0]    r_strb, r_fwd_strb;
  logic          r_wr_pend, r_fwd_en;
  logic [31:0]   r_fwd_data, r_hrdata;

  logic          w_accept, w_err, w_in_range, w_misalign, w_commit, w_rd_phase, w_fwd_hit;
  logic [AW-1:0] w_word;
  logic [3:0]    w_strb;
  logic [31:0]   w_mem_rdata, w_rdata_merged;
  logic          w_unused;

  assign w_unused = ^{hburst_i, htrans_i[0], 3'(WAIT_CYCLES)};

  assign w_accept = hsel_i & htrans_i[1] & hready_i &
                    (r_state == StIdle || r_state == StData || r_state == StErr2);

  // BASE_ADDR is aligned to the window size, so range is a compare of the high bits.
  assign w_in_range = (haddr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign w_misalign = ((hsize_i == HSIZE_HALF) & haddr_i[0]) |
                      ((hsize_i == HSIZE_WORD) & (|haddr_i[1:0]));
  assign w_err      = ~w_in_range | (hsize_i > HSIZE_WORD) | w_misalign;
  assign w_word     = haddr_i[AW+1:2];
  assign w_strb     = byte_lanes(haddr_i[1:0], hsize_i);

  assign w_commit   = (r_state == StData) & r_wr_pend;
  assign w_rd_phase = (r_state == StData) & ~r_wr_pend;
  assign w_fwd_hit  = w_commit & ~hwrite_i & ~w_err & (w_word == r_word);

`ifdef AHBL_SRAM_WAIT_STATE_EN
  localparam logic [2:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);
  localparam ahbl_state_e OK_NEXT = (WAIT_CYCLES == 0) ? StData : StWait;
  logic [2:0] r_wait_cnt, w_wait_cnt_d;
`else
  localparam ahbl_state_e OK_NEXT = StData;
`endif

  always_comb begin
    w_state_d = r_state;
`ifdef AHBL_SRAM_WAIT_STATE_EN
    w_wait_cnt_d = r_wait_cnt;
`endif
    unique case (r_state)
      StIdle, StData, StErr2: begin
        if (w_accept) begin
          w_state_d = w_err ? StErr1 : OK_NEXT;
`ifdef AHBL_SRAM_WAIT_STATE_EN
          w_wait_cnt_d = WAIT_INIT;
`endif
        end else begin
          w_state_d = StIdle;
        end
      end
      StWait: begin
`ifdef AHBL_SRAM_WAIT_STATE_EN
        if (r_wait_cnt == 3'd0) begin
          w_state_d = StData;
        end else begin
          w_wait_cnt_d = r_wait_cnt - 3'd1;
        end
`else
        w_state_d = StIdle;
`endif
      end
      StErr1:  w_state_d = StErr2;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_word     <= '0;
      r_strb     <= '0;
      r_wr_pend  <= 1'b0;
      r_fwd_en   <= 1'b0;
      r_fwd_strb <= '0;
      r_fwd_data <= '0;
      r_hrdata   <= '0;
`ifdef AHBL_SRAM_WAIT_STATE_EN
      r_wait_cnt <= '0;
`endif
    end else begin
      r_state <= w_state_d;
`ifdef AHBL_SRAM_WAIT_STATE_EN
      r_wait_cnt <= w_wait_cnt_d;
`endif
      if (w_accept) begin
        r_word     <= w_word;
        r_strb     <= w_strb;
        r_wr_pend  <= hwrite_i & ~w_err;
        r_fwd_en   <= w_fwd_hit;
        r_fwd_strb <= r_strb;
        r_fwd_data <= hwdata_i;
      end
      if (w_rd_phase) begin
        r_hrdata <= w_rdata_merged;
      end
    end
  end

  ahbl_sram_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (clk_i),
    .i_re    (w_accept & ~hwrite_i & ~w_err),
    .i_raddr (w_word),
    .o_rdata (w_mem_rdata),
    .i_we    (w_commit ? r_strb : 4'b0000),
    .i_waddr (r_word),
    .i_wdata (hwdata_i)
  );

  always_comb begin
    w_rdata_merged = w_mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (r_fwd_en & r_fwd_strb[i]) begin
        w_rdata_merged[8*i +: 8] = r_fwd_data[8*i +: 8];
      end
    end
  end

  assign hreadyout_o = ~(r_state == StWait || r_state == StErr1);
  assign hresp_o     = (r_state == StErr1 || r_state == StErr2) ? HRESP_ERROR : HRESP_OKAY;
  assign hrdata_o    = w_rd_phase ? w_rdata_merged : r_hrdata;

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Directed bench for ahbl_sram_slave: vector table plus pipelined and reset sequences.
module tb_ahbl_sram_slave;
  import ahbl_pkg::*;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int unsigned DEPTH = 256;
`ifdef AHBL_SRAM_WAIT_STATE_EN
  localparam int unsigned WAITS    = 3;
  localparam int          EXP_WAIT = 3;
`else
  localparam int unsigned WAITS    = 1;
  localparam int          EXP_WAIT = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        hsel_i = 1'b0;
  logic [31:0] haddr_i = '0;
  logic [1:0]  htrans_i = HTRANS_IDLE;
  logic        hwrite_i = 1'b0;
  logic [2:0]  hsize_i = HSIZE_WORD;
  logic [2:0]  hburst_i = 3'd0;
  logic [31:0] hwdata_i = '0;
  logic        hready_i;
  logic        hreadyout_o;
  logic        hresp_o;
  logic [31:0] hrdata_o;

  assign hready_i = hreadyout_o;

  ahbl_sram_slave #(
    .BASE_ADDR   (BASE),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAITS)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .hsel_i      (hsel_i),
    .haddr_i     (haddr_i),
    .htrans_i    (htrans_i),
    .hwrite_i    (hwrite_i),
    .hsize_i     (hsize_i),
    .hburst_i    (hburst_i),
    .hwdata_i    (hwdata_i),
    .hready_i    (hready_i),
    .hreadyout_o (hreadyout_o),
    .hresp_o     (hresp_o),
    .hrdata_o    (hrdata_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        write;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vq[$];
  int   n_chk = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic w, input logic [1:0] t, input logic [31:0] a,
                              input logic [2:0] s, input logic [31:0] d, input logic e,
                              input logic c, input logic [31:0] r);
    vec_t v;
    v.write = w; v.trans = t; v.addr = a; v.size = s; v.wdata = d;
    v.exp_err = e; v.chk_rd = c; v.exp_rd = r;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Starts at #1 after a posedge with the bus idle; returns at #1 after the closing edge.
  task automatic data_phase(output logic first_resp, output int waits, output logic [31:0] rd,
                            output logic resp);
    @(negedge clk_i);
    first_resp = hresp_o;
    waits = 0;
    while (!hreadyout_o && waits < 16) begin
      waits++;
      @(negedge clk_i);
    end
    rd   = hrdata_o;
    resp = hresp_o;
    @(posedge clk_i); #1;
  endtask

  task automatic addr_phase(input logic w, input logic [1:0] t, input logic [31:0] a,
                            input logic [2:0] s);
    hsel_i = 1'b1; htrans_i = t; hwrite_i = w; haddr_i = a; hsize_i = s;
  endtask

  task automatic bus_idle();
    hsel_i = 1'b0; htrans_i = HTRANS_IDLE; hwrite_i = 1'b0;
  endtask

  initial begin
    logic        fr, rs;
    logic [31:0] rd;
    int          wt;
    int          exp_w;

    vq.push_back(mk(1, HTRANS_NONSEQ, BASE + 32'h000, HSIZE_WORD, 32'hCAFEF00D, 0, 0, '0));
    vq.push_back(mk(1, HTRANS_NONSEQ, BASE + 32'h010, HSIZE_WORD, 32'hDEADBEEF, 0, 0, '0));
    vq.push_back(mk(0, HTRANS_NONSEQ, BASE + 32'h010, HSIZE_WORD, 32'h0, 0, 1, 32'hDEADBEEF));
    vq.push_back(mk(1, HTRANS_NONSEQ, BASE + 32'h020, HSIZE_WORD, 32'h11223344, 0, 0, '0));
    vq.push_back(mk(1, HTRANS_SEQ,    BASE + 32'h021, HSIZE_BYTE, 32'h0000AA00, 0, 0, '0));
    vq.push_back(mk(1, HTRANS_NONSEQ, BASE + 32'h022, HSIZE_HALF, 32'h55660000, 0, 0, '0));
    vq.push_back(mk(0, HTRANS_NONSEQ, BASE + 32'h020, HSIZE_WORD, 32'h0, 0, 1, 32'h5566AA44));
    vq.push_back(mk(0, HTRANS_NONSEQ, BASE + 32'h021, HSIZE_BYTE, 32'h0, 0, 1, 32'h5566AA44));
    vq.push_back(mk(0, HTRANS_NONSEQ, BASE + 32'h400, HSIZE_WORD, 32'h0, 1, 1, 32'h5566AA44));
    vq.push_back(mk(1, HTRANS_NONSEQ, BASE + 32'h002, HSIZE_WORD, 32'hFFFFFFFF, 1, 0, '0));
    vq.push_back(mk(0, HTRANS_NONSEQ, BASE + 32'h000, HSIZE_WORD, 32'h0, 0, 1, 32'hCAFEF00D));
    vq.push_back(mk(0, HTRANS_NONSEQ, BASE - 32'h004, HSIZE_WORD, 32'h0, 1, 1, 32'hCAFEF00D));
    vq.push_back(mk(0, HTRANS_NONSEQ, BASE + 32'h010, 3'd3,       32'h0, 1, 1, 32'hCAFEF00D));
    vq.push_back(mk(0, HTRANS_NONSEQ, BASE + 32'h011, HSIZE_HALF, 32'h0, 1, 0, '0));
    vq.push_back(mk(0, HTRANS_NONSEQ, BASE + 32'h012, HSIZE_WORD, 32'h0, 1, 0, '0));
    vq.push_back(mk(0, HTRANS_IDLE,   BASE + 32'h010, HSIZE_WORD, 32'h0, 0, 1, 32'hCAFEF00D));
    vq.push_back(mk(0, HTRANS_BUSY,   BASE + 32'h010, HSIZE_WORD, 32'h0, 0, 1, 32'hCAFEF00D));
    vq.push_back(mk(1, HTRANS_NONSEQ, BASE + 32'h3FC, HSIZE_WORD, 32'h0BADF00D, 0, 0, '0));
    vq.push_back(mk(0, HTRANS_NONSEQ, BASE + 32'h3FC, HSIZE_WORD, 32'h0, 0, 1, 32'h0BADF00D));
    vq.push_back(mk(0, HTRANS_NONSEQ, BASE + 32'h012, HSIZE_HALF, 32'h0, 0, 1, 32'hDEADBEEF));
    vq.push_back(mk(1, HTRANS_NONSEQ, BASE + 32'h040, HSIZE_WORD, 32'h01020304, 0, 0, '0));
    vq.push_back(mk(1, HTRANS_NONSEQ, BASE + 32'h030, HSIZE_WORD, 32'hA5A5A5A5, 0, 0, '0));

    // Reset values
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_hreadyout", 32'(hreadyout_o), 32'd1);
    check("rst_hresp", 32'(hresp_o), 32'd0);
    check("rst_hrdata", hrdata_o, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    foreach (vq[i]) begin
      addr_phase(vq[i].write, vq[i].trans, vq[i].addr, vq[i].size);
      @(posedge clk_i); #1;
      bus_idle();
      hwdata_i = vq[i].wdata;
      data_phase(fr, wt, rd, rs);
      exp_w = vq[i].exp_err ? 1 : (vq[i].trans[1] ? EXP_WAIT : 0);
      check($sformatf("v%0d_resp1", i), 32'(fr), 32'(vq[i].exp_err));
      check($sformatf("v%0d_resp", i), 32'(rs), 32'(vq[i].exp_err));
      check($sformatf("v%0d_waits", i), 32'(wt), 32'(exp_w));
      if (vq[i].chk_rd) check($sformatf("v%0d_rdata", i), rd, vq[i].exp_rd);
    end

    // Back-to-back write then read of the same word: full word, then a single byte lane.
    for (int k = 0; k < 2; k++) begin
      logic [31:0] wd, exp;
      wd  = (k == 0) ? 32'h12345678 : 32'h0000EE00;
      exp = (k == 0) ? 32'h12345678 : 32'h1234EE78;
      addr_phase(1'b1, HTRANS_NONSEQ, BASE + ((k == 0) ? 32'h30 : 32'h31),
                 (k == 0) ? HSIZE_WORD : HSIZE_BYTE);
      @(posedge clk_i); #1;
      addr_phase(1'b0, HTRANS_NONSEQ, BASE + 32'h30, HSIZE_WORD);
      hwdata_i = wd;
      wt = 0;
      @(negedge clk_i);
      while (!hreadyout_o && wt < 16) begin
        wt++;
        @(negedge clk_i);
      end
      check($sformatf("raw%0d_wr_waits", k), 32'(wt), 32'(EXP_WAIT));
      @(posedge clk_i); #1;
      bus_idle();
      hwdata_i = 32'h0;
      data_phase(fr, wt, rd, rs);
      check($sformatf("raw%0d_rd_waits", k), 32'(wt), 32'(EXP_WAIT));
      check($sformatf("raw%0d_rd_resp", k), 32'(rs), 32'd0);
      check($sformatf("raw%0d_rdata", k), rd, exp);
    end

    // Reset while a write to BASE+0x40 is in flight drops the write.
    addr_phase(1'b1, HTRANS_NONSEQ, BASE + 32'h40, HSIZE_WORD);
    @(posedge clk_i); #1;
    bus_idle();
    hwdata_i = 32'hFFFF_FFFF;
    rst_i = 1'b1;
    #1;
    check("midrst_hreadyout", 32'(hreadyout_o), 32'd1);
    check("midrst_hresp", 32'(hresp_o), 32'd0);
    check("midrst_hrdata", hrdata_o, 32'd0);
    repeat (EXP_WAIT + 2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    addr_phase(1'b0, HTRANS_NONSEQ, BASE + 32'h40, HSIZE_WORD);
    @(posedge clk_i); #1;
    bus_idle();
    data_phase(fr, wt, rd, rs);
    check("midrst_readback", rd, 32'h01020304);
    check("midrst_rd_waits", 32'(wt), 32'(EXP_WAIT));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
